// File: rtl/if_fetch_if.sv
// Byte-wide instruction-memory bus between the fetch stage (master) and memory (slave).
// Read data is valid exactly one cycle after its strobe; there is no backpressure.
interface if_fetch_if;
    logic        mem_rd;
    logic [31:0] mem_a;
    logic [7:0]  mem_din;

    modport master (
        output mem_rd,
        output mem_a,
        input  mem_din
    );

    modport slave (
        input  mem_rd,
        input  mem_a,
        output mem_din
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: four byte reads per instruction, little-endian assembly, decode redirect.
// Optional IF_MISALIGN_CHECK_EN halts on a misaligned redirect target instead of aligning it.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    if_fetch_if.master  imem,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        valid_o
`ifdef IF_MISALIGN_CHECK_EN
    ,
    output logic        misalign_o
`endif
);

    typedef enum logic [2:0] {
        StIssue0,
        StIssue1,
        StIssue2,
        StIssue3,
        StWait
`ifdef IF_MISALIGN_CHECK_EN
        ,
        StHalt
`endif
    } state_e;

    state_e      state_q;
    logic [31:0] fpc_q;
    logic [31:0] ibuf_q;
    logic        pend_q;      // a byte requested last cycle returns this cycle
    logic [1:0]  pend_idx_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic        valid_q;

    logic        issue;
    logic [1:0]  issue_idx;
    logic        strobe;
    logic        halted;
    logic        redirect;
    logic [31:0] jump_tgt;
    logic [7:0]  byte3;

    always_comb begin
        issue     = 1'b0;
        issue_idx = 2'd0;
        unique case (state_q)
            StIssue0: begin issue = 1'b1; issue_idx = 2'd0; end
            StIssue1: begin issue = 1'b1; issue_idx = 2'd1; end
            StIssue2: begin issue = 1'b1; issue_idx = 2'd2; end
            StIssue3: begin issue = 1'b1; issue_idx = 2'd3; end
            default: begin issue = 1'b0; issue_idx = 2'd0; end
        endcase
    end

    // Gating with rst_n keeps the strobe low while reset is held.
    assign strobe      = rst_n & issue & ~stall_i & ~jump_i;
    assign imem.mem_rd = strobe;
    assign imem.mem_a  = strobe ? (fpc_q + {30'd0, issue_idx}) : 32'd0;

`ifdef IF_MISALIGN_CHECK_EN
    logic misalign_q;
    assign halted     = (state_q == StHalt);
    assign jump_tgt   = jump_addr_i;
    assign misalign_o = misalign_q;
`else
    assign halted     = 1'b0;
    assign jump_tgt   = jump_addr_i & ~32'h3;
`endif

    assign redirect = jump_i & ~stall_i & ~halted;

    // Byte 3 is live on the bus unless a stall already parked it in ibuf.
    assign byte3 = pend_q ? imem.mem_din : ibuf_q[31:24];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIssue0;
            fpc_q      <= RESET_PC;
            ibuf_q     <= 32'd0;
            pend_q     <= 1'b0;
            pend_idx_q <= 2'd0;
            pc_q       <= 32'd0;
            inst_q     <= 32'd0;
            valid_q    <= 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            if (pend_q && !redirect) begin
                ibuf_q[{pend_idx_q, 3'b000} +: 8] <= imem.mem_din;
            end
            pend_q     <= strobe;
            pend_idx_q <= issue_idx;

            if (!stall_i) begin
                valid_q <= 1'b0;
                if (halted) begin
                    state_q <= state_q;
                end else if (jump_i) begin
                    fpc_q   <= jump_tgt;
                    state_q <= StIssue0;
`ifdef IF_MISALIGN_CHECK_EN
                    if (jump_addr_i[1:0] != 2'b00) begin
                        misalign_q <= 1'b1;
                        state_q    <= StHalt;
                    end
`endif
                end else begin
                    case (state_q)
                        StIssue0: state_q <= StIssue1;
                        StIssue1: state_q <= StIssue2;
                        StIssue2: state_q <= StIssue3;
                        StIssue3: state_q <= StWait;
                        StWait: begin
                            state_q <= StIssue0;
                            inst_q  <= {byte3, ibuf_q[23:0]};
                            pc_q    <= fpc_q;
                            valid_q <= 1'b1;
                            fpc_q   <= fpc_q + 32'd4;
                        end
                        default: state_q <= StIssue0;
                    endcase
                end
            end
        end
    end

    assign pc_o    = pc_q;
    assign inst_o  = inst_q;
    assign valid_o = valid_q;

endmodule
